// File: rtl/stream_pool_unit.sv
// Streaming POOL_SIZE x POOL_SIZE non-overlapping pooler that keeps one row of partial windows.
// Build option POOL_AVG_EN adds average pooling; without it the block is max-only and pool_mode is ignored.
module stream_pool_unit #(
    parameter int CHANNELS         = 8,
    parameter int FEATURE_BITWIDTH = 8,
    parameter int INPUT_WIDTH      = 12,
    parameter int INPUT_HEIGHT     = 12,
    parameter int POOL_SIZE        = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 soft_rst,
    input  logic                                 pool_mode,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [CHANNELS*FEATURE_BITWIDTH-1:0] s_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [CHANNELS*FEATURE_BITWIDTH-1:0] m_data,
    output logic                                 m_last,
    output logic                                 frame_done
);
    localparam int OUTPUT_WIDTH  = INPUT_WIDTH / POOL_SIZE;
    localparam int OUTPUT_HEIGHT = INPUT_HEIGHT / POOL_SIZE;
    localparam int POOL_LOG2     = $clog2(POOL_SIZE);
`ifdef POOL_AVG_EN
    localparam int ACC_BITWIDTH  = FEATURE_BITWIDTH + 2 * POOL_LOG2;
`else
    localparam int ACC_BITWIDTH  = FEATURE_BITWIDTH;
`endif
    localparam int DW    = CHANNELS * FEATURE_BITWIDTH;
    localparam int COL_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
    localparam int ROW_W = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1;
    localparam int WX_W  = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1;

    localparam logic [COL_W-1:0]     COL_MAX      = COL_W'(INPUT_WIDTH - 1);
    localparam logic [ROW_W-1:0]     ROW_MAX      = ROW_W'(INPUT_HEIGHT - 1);
    localparam logic [COL_W:0]       COL_LIM      = (COL_W + 1)'(OUTPUT_WIDTH * POOL_SIZE);
    localparam logic [ROW_W:0]       ROW_LIM      = (ROW_W + 1)'(OUTPUT_HEIGHT * POOL_SIZE);
    localparam logic [COL_W-1:0]     COL_LAST_WIN = COL_W'(OUTPUT_WIDTH * POOL_SIZE - 1);
    localparam logic [ROW_W-1:0]     ROW_LAST_WIN = ROW_W'(OUTPUT_HEIGHT * POOL_SIZE - 1);
    localparam logic [POOL_LOG2-1:0] SUB_MAX      = POOL_LOG2'(POOL_SIZE - 1);

    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [POOL_LOG2-1:0]    cx_q, cx_d, ry_q, ry_d;
    logic [WX_W-1:0]         wx_q, wx_d, wx_idx_s;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic                    frame_done_q, frame_done_d;
    logic [DW-1:0]           m_data_q, m_data_d, pooled_s;
    logic [ACC_BITWIDTH-1:0] acc_q [OUTPUT_WIDTH][CHANNELS];
    logic [ACC_BITWIDTH-1:0] acc_d [OUTPUT_WIDTH][CHANNELS];

    logic accept_s, in_region_s, win_first_s, win_final_s, last_win_s, origin_s, eff_mode_s;

    assign s_ready     = !m_valid_q || m_ready;
    assign accept_s    = s_valid && s_ready;
    assign in_region_s = ({1'b0, col_q} < COL_LIM) && ({1'b0, row_q} < ROW_LIM);
    assign win_first_s = (cx_q == '0) && (ry_q == '0);
    assign win_final_s = (cx_q == SUB_MAX) && (ry_q == SUB_MAX);
    assign last_win_s  = (col_q == COL_LAST_WIN) && (row_q == ROW_LAST_WIN);
    assign origin_s    = (col_q == '0) && (row_q == '0);
    // Ragged-edge beats may push wx past the last window; keep the storage index in range.
    assign wx_idx_s    = in_region_s ? wx_q : '0;

`ifdef POOL_AVG_EN
    logic mode_q, mode_d;
    // The first beat of a frame already runs in the mode being latched on it.
    assign eff_mode_s = origin_s ? pool_mode : mode_q;

    // Frame mode latch: captured on the accepted beat at the frame origin.
    always_comb begin
        mode_d = mode_q;
        if (soft_rst) begin
            mode_d = 1'b0;
        end else if (accept_s && origin_s) begin
            mode_d = pool_mode;
        end else begin
            mode_d = mode_q;
        end
    end

    // Mode register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end
`else
    logic unused_pool_mode_s;
    assign unused_pool_mode_s = pool_mode;
    assign eff_mode_s         = 1'b0;
`endif

    // Raster position and window sub-counters, advanced only by accepted beats.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        cx_d  = cx_q;
        ry_d  = ry_q;
        wx_d  = wx_q;
        if (soft_rst) begin
            col_d = '0;
            row_d = '0;
            cx_d  = '0;
            ry_d  = '0;
            wx_d  = '0;
        end else if (accept_s) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                cx_d  = '0;
                wx_d  = '0;
                if (row_q == ROW_MAX) begin
                    row_d = '0;
                    ry_d  = '0;
                end else begin
                    row_d = row_q + 1'b1;
                    ry_d  = ry_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
                cx_d  = cx_q + 1'b1;
                if (cx_q == SUB_MAX) begin
                    wx_d = wx_q + 1'b1;
                end else begin
                    wx_d = wx_q;
                end
            end
        end else begin
            col_d = col_q;
        end
    end

    // Per-channel combine of the stored partial window with the incoming pixel.
    always_comb begin
        logic [ACC_BITWIDTH-1:0] pix_v;
        logic [ACC_BITWIDTH-1:0] cur_v;
        logic [ACC_BITWIDTH-1:0] comb_v;
        logic [ACC_BITWIDTH-1:0] avg_v;
        acc_d    = acc_q;
        pooled_s = '0;
        pix_v    = '0;
        cur_v    = '0;
        comb_v   = '0;
        avg_v    = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            pix_v = ACC_BITWIDTH'(s_data[ch*FEATURE_BITWIDTH +: FEATURE_BITWIDTH]);
            cur_v = acc_q[wx_idx_s][ch];
            if (eff_mode_s) begin
                comb_v = cur_v + pix_v;
                avg_v  = comb_v >> (2 * POOL_LOG2);
            end else begin
                comb_v = (cur_v > pix_v) ? cur_v : pix_v;
                avg_v  = comb_v;
            end
            pooled_s[ch*FEATURE_BITWIDTH +: FEATURE_BITWIDTH] = avg_v[FEATURE_BITWIDTH-1:0];
            if (accept_s && !soft_rst && in_region_s && !win_final_s) begin
                acc_d[wx_idx_s][ch] = win_first_s ? pix_v : comb_v;
            end else begin
                acc_d[wx_idx_s][ch] = acc_q[wx_idx_s][ch];
            end
        end
    end

    // Output register: a new result may replace one being handed off in the same cycle.
    always_comb begin
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_data_d     = m_data_q;
        frame_done_d = 1'b0;
        if (soft_rst) begin
            m_valid_d    = 1'b0;
            m_last_d     = 1'b0;
            m_data_d     = '0;
            frame_done_d = 1'b0;
        end else begin
            frame_done_d = m_valid_q && m_ready && m_last_q;
            if (accept_s && in_region_s && win_final_s) begin
                m_valid_d = 1'b1;
                m_last_d  = last_win_s;
                m_data_d  = pooled_s;
            end else if (m_ready) begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end else begin
                m_valid_d = m_valid_q;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            cx_q         <= '0;
            ry_q         <= '0;
            wx_q         <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            cx_q         <= cx_d;
            ry_q         <= ry_d;
            wx_q         <= wx_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Window storage needs no reset: the first beat of every window overwrites it.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign m_data     = m_data_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_stream_pool_unit.sv
// Self-checking bench for stream_pool_unit: table vectors, directed corner sequences and a
// randomized run scored against a frame-array reference model.
module tb_stream_pool_unit;
    localparam int W = 12, H = 12, P = 2, OW = W / P, OH = H / P, CH = 8;
`ifdef POOL_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, soft_rst, pool_mode, s_valid, s_ready, m_valid, m_ready, m_last, frame_done;
    logic [63:0] s_data, m_data;
    logic r_s_valid, r_s_ready, r_m_valid, r_m_ready, r_m_last, r_frame_done, r_pool_mode;
    logic [63:0] r_s_data, r_m_data;

    stream_pool_unit #(.CHANNELS(CH), .FEATURE_BITWIDTH(8), .INPUT_WIDTH(W), .INPUT_HEIGHT(H), .POOL_SIZE(P)) dut (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .pool_mode(pool_mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .frame_done(frame_done));

    stream_pool_unit #(.CHANNELS(CH), .FEATURE_BITWIDTH(8), .INPUT_WIDTH(13), .INPUT_HEIGHT(13), .POOL_SIZE(P)) dut_r (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .pool_mode(r_pool_mode),
        .s_valid(r_s_valid), .s_ready(r_s_ready), .s_data(r_s_data),
        .m_valid(r_m_valid), .m_ready(r_m_ready), .m_data(r_m_data), .m_last(r_m_last), .frame_done(r_frame_done));

    typedef struct { logic [63:0] data; logic last; } exp_t;
    typedef struct { logic [7:0] a, b, c, d; logic mode; logic [7:0] exp_avg, exp_max; } vec_t;

    int checks = 0, errors = 0;
    exp_t exp_q[$];
    logic [63:0] out_log[$], r_log[$];
    int fd_count, r_fd_count, stall_cnt, r_acc_cnt, r_last_idx;
    logic [7:0] img [0:H-1][0:W-1][0:CH-1];
    int mx, my;
    logic mmode, fd_exp;
    bit force_low, rnd_ready, rnd_gap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: store each accepted pixel at its raster position; a completed window is pooled from the array.
    task automatic model_beat(input logic [63:0] d, input logic pm);
        exp_t e;
        if (mx == 0 && my == 0) mmode = pm & AVG_EN;
        for (int ch = 0; ch < CH; ch++) img[my][mx][ch] = d[ch*8 +: 8];
        if (mx % P == P - 1 && my % P == P - 1 && mx < OW * P && my < OH * P) begin
            e.data = '0;
            for (int ch = 0; ch < CH; ch++) begin
                int sum, mxv;
                sum = 0; mxv = 0;
                for (int dy = 0; dy < P; dy++)
                    for (int dx = 0; dx < P; dx++) begin
                        sum += int'(img[my-dy][mx-dx][ch]);
                        if (int'(img[my-dy][mx-dx][ch]) > mxv) mxv = int'(img[my-dy][mx-dx][ch]);
                    end
                e.data[ch*8 +: 8] = mmode ? 8'(sum / (P * P)) : 8'(mxv);
            end
            e.last = (mx / P == OW - 1) && (my / P == OH - 1);
            exp_q.push_back(e);
        end
        mx++;
        if (mx == W) begin mx = 0; my++; if (my == H) my = 0; end
    endtask

    // Monitor on the falling edge: handshake rules, scoreboard, then model update for this cycle's beat.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("s_ready", 64'(s_ready), 64'(!m_valid || m_ready));
            chk("frame_done", 64'(frame_done), 64'(fd_exp));
            if (frame_done) fd_count++;
            if (s_valid && !s_ready) stall_cnt++;
            if (m_valid && m_ready) begin
                out_log.push_back(m_data);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_output: got %h expected none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e.data);
                    chk("m_last", 64'(m_last), 64'(e.last));
                end
            end
            if (r_m_valid && r_m_ready) begin
                r_log.push_back(r_m_data);
                if (r_m_last) r_last_idx = r_log.size();
            end
            if (r_frame_done) r_fd_count++;
            if (r_s_valid && r_s_ready) r_acc_cnt++;
        end
        fd_exp = rst_n && !soft_rst && m_valid && m_ready && m_last;
        if (!rst_n || soft_rst) begin
            mx = 0; my = 0; exp_q.delete();
        end else if (s_valid && s_ready) begin
            model_beat(s_data, pool_mode);
        end
    end

    // Downstream ready generator.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_ready = force_low ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic pm);
        int t;
        t = 0;
        s_valid = 1'b1; s_data = d; pool_mode = pm;
        @(negedge clk);
        while (!s_ready && t < 500) begin t++; @(negedge clk); end
        if (!s_ready) begin checks++; errors++; $display("FAIL s_ready_timeout: got 0 expected 1"); end
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = {$urandom, $urandom};
        if (rnd_gap && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    endtask

    task automatic send_ramp(input bit toggle);
        for (int b = 0; b < W * H; b++) begin
            logic [7:0] v;
            v = 8'(b);
            send_beat({8{v}}, toggle && b >= 5);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < 3000) begin t++; @(negedge clk); end
        if (exp_q.size() != 0 || m_valid) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic ramp_check(input string tag);
        chk({tag, "_count"}, 64'(out_log.size()), 64'(OW * OH));
        for (int k = 0; k < out_log.size() && k < OW * OH; k++) begin
            logic [7:0] v;
            v = 8'((2 * (k / OW) + 1) * W + 2 * (k % OW) + 1);
            chk(tag, out_log[k], {8{v}});
        end
    endtask

    initial begin
        vec_t tbl [6];
        tbl[0] = '{8'd10, 8'd20, 8'd30, 8'd41, 1'b1, 8'd25, 8'd41};
        tbl[1] = '{8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 8'd255, 8'd255};
        tbl[2] = '{8'd10, 8'd20, 8'd30, 8'd41, 1'b0, 8'd41, 8'd41};
        tbl[3] = '{8'd200, 8'd3, 8'd7, 8'd9, 1'b0, 8'd200, 8'd200};
        tbl[4] = '{8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 8'd2, 8'd4};
        tbl[5] = '{8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 8'd0, 8'd0};

        rst_n = 1'b0; soft_rst = 1'b0; pool_mode = 1'b0; s_valid = 1'b0; s_data = '0;
        r_s_valid = 1'b0; r_s_data = '0; r_m_ready = 1'b1; r_pool_mode = 1'b0;
        force_low = 1'b0; rnd_ready = 1'b0; rnd_gap = 1'b0;
        mx = 0; my = 0; mmode = 1'b0; fd_exp = 1'b0;
        fd_count = 0; r_fd_count = 0; stall_cnt = 0; r_acc_cnt = 0; r_last_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Max pooling of a ramp frame at full throughput.
        out_log.delete(); fd_count = 0;
        send_ramp(1'b0);
        drain();
        ramp_check("max_ramp");
        chk("max_ramp_frame_done", 64'(fd_count), 64'd1);

        // Window vectors placed in the top-left window of otherwise random frames.
        for (int n = 0; n < 6; n++) begin
            out_log.delete();
            for (int b = 0; b < W * H; b++) begin
                logic [7:0] v;
                case (b)
                    0:       v = tbl[n].a;
                    1:       v = tbl[n].b;
                    W:       v = tbl[n].c;
                    W + 1:   v = tbl[n].d;
                    default: v = 8'($urandom);
                endcase
                send_beat({8{v}}, tbl[n].mode);
            end
            drain();
            chk("table_window", out_log[0], {8{(AVG_EN && tbl[n].mode) ? tbl[n].exp_avg : tbl[n].exp_max}});
        end

        // Randomized frames: random data, random mode per beat, gaps and downstream stalls.
        rnd_ready = 1'b1; rnd_gap = 1'b1;
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < W * H; b++) send_beat({$urandom, $urandom}, 1'($urandom));
        drain();
        rnd_ready = 1'b0; rnd_gap = 1'b0;

        // Long backpressure: m_ready low for 20 cycles while the source keeps pushing.
        out_log.delete(); stall_cnt = 0;
        force_low = 1'b1; m_ready = 1'b0;
        fork
            send_ramp(1'b0);
            begin repeat (20) @(posedge clk); force_low = 1'b0; end
        join
        drain();
        ramp_check("backpressure");
        chk("backpressure_stalled", 64'(stall_cnt > 0), 64'd1);

        // Soft reset after 50 beats, colliding with an accepted beat that must be dropped.
        for (int b = 0; b < 50; b++) send_beat({$urandom, $urandom}, 1'b0);
        soft_rst = 1'b1; s_valid = 1'b1; s_data = {$urandom, $urandom};
        @(posedge clk); #1;
        soft_rst = 1'b0; s_valid = 1'b0;
        chk("soft_rst_m_valid", 64'(m_valid), 64'd0);
        out_log.delete();
        send_ramp(1'b0);
        drain();
        ramp_check("soft_rst");

        // pool_mode raised at beat 5 of a max frame must not change that frame.
        out_log.delete();
        send_ramp(1'b1);
        drain();
        ramp_check("mode_toggle");

        // Asynchronous reset while a result is held.
        force_low = 1'b1; m_ready = 1'b0;
        for (int b = 0; b < W + 2; b++) begin
            logic [7:0] v;
            v = 8'(b);
            send_beat({8{v}}, 1'b0);
        end
        chk("pre_async_m_valid", 64'(m_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_m_valid", 64'(m_valid), 64'd0);
        chk("async_m_data", m_data, 64'd0);
        chk("async_m_last", 64'(m_last), 64'd0);
        chk("async_frame_done", 64'(frame_done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; force_low = 1'b0; m_ready = 1'b1;
        out_log.delete();
        send_ramp(1'b0);
        drain();
        ramp_check("async_rst");

        // Ragged 13x13 frame: column 12 and row 12 carry 255 and must never reach an output.
        r_log.delete(); r_acc_cnt = 0; r_fd_count = 0; r_last_idx = 0;
        for (int y = 0; y < 13; y++)
            for (int x = 0; x < 13; x++) begin
                logic [7:0] v;
                v = (x == 12 || y == 12) ? 8'd255 : 8'(y * 13 + x);
                r_s_valid = 1'b1; r_s_data = {8{v}};
                @(posedge clk); #1;
            end
        r_s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ragged_accepted", 64'(r_acc_cnt), 64'd169);
        chk("ragged_count", 64'(r_log.size()), 64'd36);
        chk("ragged_last_index", 64'(r_last_idx), 64'd36);
        chk("ragged_frame_done", 64'(r_fd_count), 64'd1);
        for (int k = 0; k < r_log.size() && k < 36; k++) begin
            logic [7:0] v;
            v = 8'((2 * (k / 6) + 1) * 13 + 2 * (k % 6) + 1);
            chk("ragged_data", r_log[k], {8{v}});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
